// File: rtl/instruction_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// Latency: none of its own; it only carries signals.
// Backpressure: mem_read is held by the master until the slave pulses mem_ready.
// Ports: mem_address/mem_read from master; mem_ready/mem_data from slave.
interface instruction_fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (
    output mem_address,
    output mem_read,
    input  mem_ready,
    input  mem_data
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    output mem_ready,
    output mem_data
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: requests words from instruction memory, tracks the PC, handles redirects.
// Latency: instruction_valid rises the cycle after the edge that samples mem_ready; >= 2 cycles/instr.
// Backpressure: i_stall holds the registered instruction and PC; memory waits are absorbed in FETCH.
// Ports: i_clk, i_rst_n (async, active-low); mem_bus (master side of instruction_fetch_if);
//        i_stall, i_branch_taken, i_branch_target in; o_instruction, o_instruction_pc,
//        o_instruction_valid out to decode / immediate extension.
module instruction_fetch #(
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_ADDRESS = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  instruction_fetch_if.master   mem_bus,
  input  logic                  i_stall,
  input  logic                  i_branch_taken,
  input  logic [DATA_WIDTH-1:0] i_branch_target,
  output logic [DATA_WIDTH-1:0] o_instruction,
  output logic [DATA_WIDTH-1:0] o_instruction_pc,
  output logic                  o_instruction_valid
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DISCARD = 2'd1,
    S_VALID   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_discard_addr;
  logic [DATA_WIDTH-1:0] w_discard_addr_nxt;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] w_instr_nxt;
  logic [DATA_WIDTH-1:0] r_instr_pc;
  logic [DATA_WIDTH-1:0] w_instr_pc_nxt;
  logic                  w_mem_read;
  logic [DATA_WIDTH-1:0] w_target;
  logic [DATA_WIDTH-1:0] w_pc_inc;
  logic                  w_unused_target_lsbs;

  // Targets are word aligned; the two low bits are dropped.
  assign w_target             = {i_branch_target[DATA_WIDTH-1:2], 2'b00};
  assign w_unused_target_lsbs = ^i_branch_target[1:0];
  // Wraps naturally modulo 2^DATA_WIDTH.
  assign w_pc_inc             = r_pc + DATA_WIDTH'(4);

  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_discard_addr_nxt = r_discard_addr;
    w_instr_nxt        = r_instr;
    w_instr_pc_nxt     = r_instr_pc;
    w_mem_read         = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (i_branch_taken) begin
          // Redirect wins over a same-cycle return; the word is for the old path.
          w_pc_nxt = w_target;
          if (!mem_bus.mem_ready) begin
            // The outstanding request must still be drained at its original address.
            w_state_nxt        = S_DISCARD;
            w_discard_addr_nxt = r_pc;
          end
        end else if (mem_bus.mem_ready) begin
          w_instr_nxt    = mem_bus.mem_data;
          w_instr_pc_nxt = r_pc;
          w_pc_nxt       = w_pc_inc;
          w_state_nxt    = S_VALID;
        end
      end

      S_DISCARD: begin
        w_mem_read = 1'b1;
        if (i_branch_taken) begin
          w_pc_nxt = w_target;
        end
        if (mem_bus.mem_ready) begin
          w_state_nxt = S_FETCH;
        end
      end

      S_VALID: begin
        // Branch has priority over stall; mem_ready is ignored here.
        if (i_branch_taken) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else if (!i_stall) begin
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_FETCH;
      r_pc           <= RESET_ADDRESS;
      r_discard_addr <= '0;
      r_instr        <= '0;
      r_instr_pc     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_discard_addr <= w_discard_addr_nxt;
      r_instr        <= w_instr_nxt;
      r_instr_pc     <= w_instr_pc_nxt;
    end
  end

  // Reset gates the request directly so no read is issued while reset is low.
  assign mem_bus.mem_read    = w_mem_read & i_rst_n;
  assign mem_bus.mem_address = (r_state == S_DISCARD) ? r_discard_addr : r_pc;

  assign o_instruction       = r_instr;
  assign o_instruction_pc    = r_instr_pc;
  assign o_instruction_valid = (r_state == S_VALID);

endmodule
